univ_shift_reg: RTL and testbench

- Parameterised universal shift register (74x194 style) built on rising-edge D flip-flops with an asynchronous clear.
- Sits directly downstream of the single-bit flip-flop cells: it consumes their storage behaviour as a W-bit register.
- Supports hold, shift right, shift left and parallel load.
- Tracks the number of shifts since the last load and flags when a full word has been shifted, so it can act as a serializer/deserializer stage.

---
 rtl/univ_shift_reg.sv | 118 +++++++++++
 tb/tb_univ_shift_reg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parameterised 74x194-style universal shift register.
// Hold, shift right, shift left and parallel load, plus a saturating count
// of shifts since the last load/clear and a registered full-word flag.
// Optional feature: define UNIV_SHIFT_REG_ROTATE_EN to add the rot input,
// which recirculates the outgoing bit instead of taking xr/xl.
module univ_shift_reg #(
  parameter  int W  = 8,
  localparam int CW = $clog2(W + 1)
) (
  input  logic          ck,
  input  logic          cl,
  input  logic          en,
  input  logic [1:0]    op,
  input  logic          xr,
  input  logic          xl,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  input  logic          rot,
`endif
  input  logic [W-1:0]  d,
  output logic [W-1:0]  q,
  output logic          sor,
  output logic          sol,
  output logic [CW-1:0] cnt,
  output logic          done
);

  localparam logic [1:0]    OP_HOLD  = 2'b00;
  localparam logic [1:0]    OP_SHR   = 2'b01;
  localparam logic [1:0]    OP_SHL   = 2'b10;
  localparam logic [1:0]    OP_LOAD  = 2'b11;
  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [W-1:0]  r_q;
  logic [CW-1:0] r_cnt;
  logic          r_done;

  logic [W-1:0]  w_q_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_done_next;
  logic          w_sr_in;
  logic          w_sl_in;
  logic [CW-1:0] w_cnt_shift;

  // Select the bit entering on a shift: external serial input or recirculated bit
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  always_comb begin
    w_sr_in = rot ? r_q[0]   : xr;
    w_sl_in = rot ? r_q[W-1] : xl;
  end
`else
  always_comb begin
    w_sr_in = xr;
    w_sl_in = xl;
  end
`endif

  // Saturating shift count: stops at W, never wraps back to zero
  always_comb begin
    w_cnt_shift = (r_cnt == CNT_FULL) ? r_cnt : r_cnt + CNT_ONE;
  end

  // Next-state decode; unused data inputs never reach the state
  always_comb begin
    w_q_next   = r_q;
    w_cnt_next = r_cnt;
    if (en) begin
      unique case (op)
        OP_HOLD: begin
          w_q_next   = r_q;
          w_cnt_next = r_cnt;
        end
        OP_SHR: begin
          w_q_next   = {w_sr_in, r_q[W-1:1]};
          w_cnt_next = w_cnt_shift;
        end
        OP_SHL: begin
          w_q_next   = {r_q[W-2:0], w_sl_in};
          w_cnt_next = w_cnt_shift;
        end
        OP_LOAD: begin
          w_q_next   = d;
          w_cnt_next = '0;
        end
        default: begin
          w_q_next   = r_q;
          w_cnt_next = r_cnt;
        end
      endcase
    end
    // done tracks the new count, so it rises with the W-1 -> W step
    // and only falls when a load brings the count back to zero
    w_done_next = (w_cnt_next == CNT_FULL);
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge ck or negedge cl) begin
    if (!cl) begin
      r_q    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_cnt  <= w_cnt_next;
      r_done <= w_done_next;
    end
  end

  // Outputs straight from state; serial outs have no extra register stage
  always_comb begin
    q    = r_q;
    cnt  = r_cnt;
    done = r_done;
    sor  = r_q[0];
    sol  = r_q[W-1];
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Testbench for univ_shift_reg (W=8): table-driven vectors checked through
// an expected-result queue, plus hand sequences for the asynchronous clear.
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          ck;
  logic          cl;
  logic          en;
  logic [1:0]    op;
  logic          xr;
  logic          xl;
  logic          rot;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic          sor;
  logic          sol;
  logic [CW-1:0] cnt;
  logic          done;

  int n_checks;
  int n_fail;

  typedef struct {
    logic          en;
    logic [1:0]    op;
    logic          xr;
    logic          xl;
    logic          rot;
    logic [W-1:0]  d;
    logic [W-1:0]  exp_q;
    logic [CW-1:0] exp_cnt;
    logic          exp_done;
    string         name;
  } vec_t;

  typedef struct {
    logic [W-1:0]  q;
    logic [CW-1:0] cnt;
    logic          done;
    string         name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  univ_shift_reg #(.W(W)) dut (
    .ck   (ck),
    .cl   (cl),
    .en   (en),
    .op   (op),
    .xr   (xr),
    .xl   (xl),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    .rot  (rot),
`endif
    .d    (d),
    .q    (q),
    .sor  (sor),
    .sol  (sol),
    .cnt  (cnt),
    .done (done)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [W-1:0] eq,
                             input logic [CW-1:0] ec, input logic ed);
    check({name, " q"},    8'(q),    8'(eq));
    check({name, " cnt"},  8'(cnt),  8'(ec));
    check({name, " done"}, 8'(done), 8'(ed));
    check({name, " sor"},  8'(sor),  8'(eq[0]));
    check({name, " sol"},  8'(sol),  8'(eq[W-1]));
  endtask

  function automatic vec_t mk(input string name, input logic e, input logic [1:0] o,
                              input logic r_in, input logic l_in, input logic rt,
                              input logic [W-1:0] dd, input logic [W-1:0] eq,
                              input logic [CW-1:0] ec, input logic ed);
    vec_t v;
    v.name = name; v.en = e; v.op = o; v.xr = r_in; v.xl = l_in; v.rot = rt;
    v.d = dd; v.exp_q = eq; v.exp_cnt = ec; v.exp_done = ed;
    return v;
  endfunction

  // Drive one vector, queue its expectation, compare after the clock edge
  task automatic step(input vec_t v);
    exp_t e;
    exp_t got;
    en = v.en; op = v.op; xr = v.xr; xl = v.xl; rot = v.rot; d = v.d;
    e.q = v.exp_q; e.cnt = v.exp_cnt; e.done = v.exp_done; e.name = v.name;
    sb.push_back(e);
    @(posedge ck);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: queue empty, expected 1 entry");
    end else begin
      got = sb.pop_front();
      check_state(got.name, got.q, got.cnt, got.done);
      $display("vec %-10s en=%0b op=%0d q=%02h cnt=%0d done=%0b", got.name, v.en, v.op, q, cnt, done);
    end
  endtask

  initial begin
    logic [W-1:0] rq;
    n_checks = 0;
    n_fail   = 0;
    cl = 1'b0; en = 1'b0; op = 2'b00; xr = 1'b0; xl = 1'b0; rot = 1'b0; d = '0;

    // Reset state while clear is held
    #1;
    check_state("reset", 8'h00, 0, 1'b0);
    @(negedge ck);
    cl = 1'b1;

    // Load/hold and en=0
    vecs.push_back(mk("ld3C",  1, 2'b11, 1, 1, 0, 8'h3C, 8'h3C, 0, 0));
    vecs.push_back(mk("hold1", 1, 2'b00, 1, 1, 0, 8'hFF, 8'h3C, 0, 0));
    vecs.push_back(mk("hold2", 1, 2'b00, 0, 1, 0, 8'h00, 8'h3C, 0, 0));
    vecs.push_back(mk("hold3", 1, 2'b00, 1, 0, 0, 8'h55, 8'h3C, 0, 0));
    vecs.push_back(mk("en0shr",0, 2'b01, 1, 1, 0, 8'hFF, 8'h3C, 0, 0));
    vecs.push_back(mk("en0ld", 0, 2'b11, 1, 1, 0, 8'hFF, 8'h3C, 0, 0));
    // Right shift of a full word; xl/d are junk and must be ignored
    vecs.push_back(mk("ldB1",  1, 2'b11, 0, 0, 0, 8'hB1, 8'hB1, 0, 0));
    vecs.push_back(mk("shr1",  1, 2'b01, 0, 1, 0, 8'hFF, 8'h58, 1, 0));
    vecs.push_back(mk("shr2",  1, 2'b01, 0, 1, 0, 8'hFF, 8'h2C, 2, 0));
    vecs.push_back(mk("shr3",  1, 2'b01, 0, 1, 0, 8'hFF, 8'h16, 3, 0));
    vecs.push_back(mk("shr4",  1, 2'b01, 0, 1, 0, 8'hFF, 8'h0B, 4, 0));
    vecs.push_back(mk("shr5",  1, 2'b01, 0, 1, 0, 8'hFF, 8'h05, 5, 0));
    vecs.push_back(mk("shr6",  1, 2'b01, 0, 1, 0, 8'hFF, 8'h02, 6, 0));
    vecs.push_back(mk("shr7",  1, 2'b01, 0, 1, 0, 8'hFF, 8'h01, 7, 0));
    vecs.push_back(mk("shr8",  1, 2'b01, 0, 1, 0, 8'hFF, 8'h00, 8, 1));
    vecs.push_back(mk("hdone", 1, 2'b00, 1, 1, 0, 8'hFF, 8'h00, 8, 1));
    vecs.push_back(mk("en0dn", 0, 2'b10, 1, 1, 0, 8'hFF, 8'h00, 8, 1));
    // Left shift with saturation; xr/d are junk
    vecs.push_back(mk("ld00",  1, 2'b11, 1, 1, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk("shl1",  1, 2'b10, 1, 1, 0, 8'hAA, 8'h01, 1, 0));
    vecs.push_back(mk("shl2",  1, 2'b10, 1, 1, 0, 8'hAA, 8'h03, 2, 0));
    vecs.push_back(mk("shl3",  1, 2'b10, 1, 1, 0, 8'hAA, 8'h07, 3, 0));
    vecs.push_back(mk("shl4",  1, 2'b10, 1, 1, 0, 8'hAA, 8'h0F, 4, 0));
    vecs.push_back(mk("shl5",  1, 2'b10, 1, 1, 0, 8'hAA, 8'h1F, 5, 0));
    vecs.push_back(mk("shl6",  1, 2'b10, 1, 1, 0, 8'hAA, 8'h3F, 6, 0));
    vecs.push_back(mk("shl7",  1, 2'b10, 1, 1, 0, 8'hAA, 8'h7F, 7, 0));
    vecs.push_back(mk("shl8",  1, 2'b10, 1, 1, 0, 8'hAA, 8'hFF, 8, 1));
    vecs.push_back(mk("shl9",  1, 2'b10, 1, 1, 0, 8'hAA, 8'hFF, 8, 1));
    vecs.push_back(mk("shl10", 1, 2'b10, 1, 1, 0, 8'hAA, 8'hFF, 8, 1));
    vecs.push_back(mk("ld5A",  1, 2'b11, 0, 0, 0, 8'h5A, 8'h5A, 0, 0));
    // Mixed direction keeps counting
    vecs.push_back(mk("ld81",  1, 2'b11, 0, 0, 0, 8'h81, 8'h81, 0, 0));
    vecs.push_back(mk("mixr",  1, 2'b01, 1, 1, 0, 8'h00, 8'hC0, 1, 0));
    vecs.push_back(mk("mixl",  1, 2'b10, 1, 0, 0, 8'h00, 8'h80, 2, 0));
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    vecs.push_back(mk("ld01",  1, 2'b11, 0, 0, 0, 8'h01, 8'h01, 0, 0));
    rq = 8'h01;
    for (int i = 1; i <= 8; i++) begin
      rq = {rq[0], rq[7:1]};
      vecs.push_back(mk($sformatf("rot%0d", i), 1, 2'b01, 0, 0, 1, 8'h00, rq,
                        CW'(i), (i == 8)));
    end
`else
    rq = 8'h00;
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
    end

    // Asynchronous clear mid-cycle from a loaded value
    step(mk("ldA5", 1, 2'b11, 0, 0, 0, 8'hA5, 8'hA5, 0, 0));
    #3;
    cl = 1'b0;
    #1;
    check_state("clr_async", 8'h00, 0, 1'b0);
    $display("clr async q=%02h cnt=%0d done=%0b", q, cnt, done);
    en = 1'b1; op = 2'b11; d = 8'hFF;
    @(posedge ck);
    #1;
    check_state("clr_held", 8'h00, 0, 1'b0);
    $display("clr held  q=%02h cnt=%0d done=%0b", q, cnt, done);
    #2;
    cl = 1'b1;
    // First edge after release works from the cleared state
    step(mk("post_clr", 1, 2'b01, 1, 0, 0, 8'hFF, 8'h80, 1, 0));

    // Clear while done is high
    step(mk("ldFF", 1, 2'b11, 0, 0, 0, 8'hFF, 8'hFF, 0, 0));
    for (int i = 1; i <= 8; i++) begin
      step(mk($sformatf("sh%0d", i), 1, 2'b10, 0, 0, 0, 8'h00,
              8'(8'hFF << i), CW'(i), (i == 8)));
    end
    @(negedge ck);
    cl = 1'b0;
    #1;
    check_state("clr_done", 8'h00, 0, 1'b0);
    $display("clr done  q=%02h cnt=%0d done=%0b", q, cnt, done);
    cl = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected test end");
    $fatal(1, "timeout");
  end

endmodule
